mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter BURST, default 8: words per cache-line fill (power of two, 2..16).
REQ-002 SHALL provide parameter AW, default 16: byte-address width.
REQ-003 SHALL provide port clk  input  1: the single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL provide ports i_req input 1, i_addr input AW: instruction-side line-fill request and miss address.
REQ-006 SHALL provide ports i_gnt output 1, i_vld output 1, i_done output 1: instruction-side grant, fill-word valid, and completion pulse.
REQ-007 SHALL provide ports d_req input 1, d_wr input 1, d_addr input AW, d_wdata input 16: data-side request, 1=single-word write / 0=line fill, address, write data.
REQ-008 SHALL provide ports d_gnt output 1, d_vld output 1, d_done output 1: data-side grant, fill-word valid, and completion pulse.
REQ-009 SHALL provide ports fill_data output 16 and fill_idx output log2(BURST): returned word and its index within the line.
REQ-010 SHALL provide ports mem_en output 1, mem_wr output 1, mem_addr output AW, mem_wdata output 16: the shared memory command.
REQ-011 SHALL provide ports mem_rdata input 16 and mem_rvld input 1: memory read return, arriving a fixed pipelined latency after each command.

Function
REQ-012 SHALL implement FSM states IDLE, FILL, WRITE, DONE, with an owner register (I/D).
REQ-013 IDLE: on a clock edge with any request, the FSM SHALL latch the owner and address, then move to FILL (fill) or WRITE (d_wr=1).
REQ-014 Simultaneous i_req and d_req SHALL resolve per REQ-027/028.
REQ-015 x_gnt SHALL be high in FILL, WRITE and DONE for the owner only (Moore output).
REQ-016 FILL issue SHALL assert mem_en for exactly BURST consecutive cycles, starting with the first FILL cycle.
REQ-017 FILL issue addresses SHALL be {line_base, issue_cnt, 1'b0}, where line_base = latched addr[AW-1:log2(BURST)+1]; addresses wrap within the line, never crossing it (e.g. the 0xFFF0 line stays at 0xFFF0..0xFFFE).
REQ-018 During FILL, each mem_rvld SHALL drive fill_data=mem_rdata and fill_idx=recv_cnt, pulse the owner's x_vld the same cycle, and increment recv_cnt.
REQ-019 The FSM SHALL move to DONE on the edge sampling the BURST-th mem_rvld, even if issue has not finished.
REQ-020 WRITE SHALL last one cycle: mem_en=1, mem_wr=1, mem_addr=latched d_addr, mem_wdata=latched d_wdata; then DONE.
REQ-021 DONE SHALL last one cycle, pulse the owner's x_done, then return to IDLE; the earliest next grant is the cycle after IDLE.
REQ-022 Requester deassertion mid-transaction SHALL be ignored; the transaction completes.
REQ-023 mem_rvld outside FILL SHALL be ignored: no x_vld and no counter change.
REQ-024 mem_wr SHALL be 0 outside WRITE; mem_en SHALL be 0 in IDLE and DONE.

Reset
REQ-025 rst SHALL immediately force IDLE, counters 0, owner I, RR pointer "D next", and all outputs 0, including mid-burst.
REQ-026 Returns still in flight at reset SHALL be dropped per REQ-023.

Configuration
REQ-027 With MEM_ARB_RR_EN defined, ties SHALL be granted round-robin: the pointer flips to the other requester after each grant.
REQ-028 Without MEM_ARB_RR_EN, ties SHALL always go to D (fixed priority), and no pointer register SHALL exist.

Structure
REQ-029 A shared package SHALL hold the state enum, owner encoding, and default BURST/AW constants.
REQ-030 A sub-module arb_pick (combinational tie-breaker plus optional RR pointer) SHALL be instantiated once.

Verification
REQ-031 Memory latency 4: i_req, i_addr=0x0046 -> issue addresses 0x0040..0x004E on 8 consecutive cycles; 8 i_vld pulses with fill_idx 0..7; i_done 1 cycle after the 8th return.
REQ-032 d_req with d_wr=1, d_addr=0x1234, d_wdata=0xBEEF -> one cycle with mem_en=mem_wr=1 at 0x1234/0xBEEF, then d_done; i_vld/d_vld stay 0.
REQ-033 i_req and d_req rise on the same edge, three times back-to-back -> without the macro, D,D,D; with MEM_ARB_RR_EN, D,I,D.
REQ-034 d_addr=0xFFFA fill -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
REQ-035 rst asserted after the 3rd return of a fill -> outputs 0 asynchronously; 5 further mem_rvld pulses produce no x_vld; a new i_req is served normally.
REQ-036 i_req dropped after the first FILL cycle -> all 8 words still returned and i_done pulses.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int BURST_DEF = 8;
  localparam int AW_DEF    = 16;
  localparam int DW        = 16;

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Tie-breaker between instruction and data requesters.
// MEM_ARB_RR_EN: alternate ties via a pointer register; otherwise D always wins ties.
module arb_pick
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic take,
`endif
  input  logic i_req,
  input  logic d_req,
  output logic pick_d
);

`ifdef MEM_ARB_RR_EN
  logic rr_d;  // 1: D wins the next tie

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_d <= 1'b1;
    end else if (take) begin
      rr_d <= ~pick_d;
    end
  end

  assign pick_d = d_req & (~i_req | rr_d);
`else
  assign pick_d = d_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one shared memory port between I-side line fills and D-side fills/writes.
// Define MEM_ARB_RR_EN for round-robin ties (default: data side wins ties).
//
//  state | meaning
//  IDLE  | no owner; grant on any request
//  FILL  | issue BURST line reads, forward returns to owner
//  WRITE | single-word data write
//  DONE  | one-cycle completion pulse to owner
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BURST = BURST_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_req,
  input  logic [AW-1:0]            i_addr,
  output logic                     i_gnt,
  output logic                     i_vld,
  output logic                     i_done,
  input  logic                     d_req,
  input  logic                     d_wr,
  input  logic [AW-1:0]            d_addr,
  input  logic [DW-1:0]            d_wdata,
  output logic                     d_gnt,
  output logic                     d_vld,
  output logic                     d_done,
  output logic [DW-1:0]            fill_data,
  output logic [$clog2(BURST)-1:0] fill_idx,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_rvld
);

  localparam int IW = $clog2(BURST);

  state_t          state_q, state_n;
  owner_t          owner_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [IW:0]     issue_cnt;  // MSB set once all BURST reads are issued
  logic [IW-1:0]   recv_cnt;
  logic            pick_d;
  logic            take;

  assign take = (state_q == IDLE) && (i_req || d_req);

  arb_pick u_pick (
`ifdef MEM_ARB_RR_EN
    .clk    (clk),
    .rst    (rst),
    .take   (take),
`endif
    .i_req  (i_req),
    .d_req  (d_req),
    .pick_d (pick_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      addr_q    <= '0;
      wdata_q   <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
    end else begin
      state_q <= state_n;
      if (take) begin
        owner_q   <= pick_d ? OWN_D : OWN_I;
        addr_q    <= pick_d ? d_addr : i_addr;
        wdata_q   <= d_wdata;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else if (state_q == FILL) begin
        if (!issue_cnt[IW]) issue_cnt <= issue_cnt + 1'b1;
        if (mem_rvld)       recv_cnt  <= recv_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_vld     = 1'b0;
    d_vld     = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    fill_data = '0;
    fill_idx  = '0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    if (state_q != IDLE) begin
      i_gnt = (owner_q == OWN_I);
      d_gnt = (owner_q == OWN_D);
    end

    unique case (state_q)
      IDLE: begin
        if (take) state_n = (pick_d && d_wr) ? WRITE : FILL;
      end
      FILL: begin
        if (!issue_cnt[IW]) begin
          mem_en   = 1'b1;
          // reads wrap inside the line; the line base never advances
          mem_addr = {addr_q[AW-1:IW+1], issue_cnt[IW-1:0], 1'b0};
        end
        if (mem_rvld) begin
          fill_data = mem_rdata;
          fill_idx  = recv_cnt;
          i_vld     = (owner_q == OWN_I);
          d_vld     = (owner_q == OWN_D);
          if (&recv_cnt) state_n = DONE;
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_n   = DONE;
      end
      DONE: begin
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: pipelined memory model, transaction-level
// reference model, directed scenarios and a randomized phase.
module tb_mem_arbiter;
  localparam int BURST = 8;
  localparam int AW    = 16;
  localparam int LAT   = 4;
  localparam int IW    = $clog2(BURST);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [15:0]   d_wdata = '0;
  logic          i_gnt, i_vld, i_done, d_gnt, d_vld, d_done;
  logic [15:0]   fill_data;
  logic [IW-1:0] fill_idx;
  logic          mem_en, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata = '0;
  logic          mem_rvld = 1'b0;

  mem_arbiter #(.BURST(BURST), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_vld(i_vld), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_vld(d_vld), .d_done(d_done),
    .fill_data(fill_data), .fill_idx(fill_idx),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvld(mem_rvld)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_rvld  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  // memory: fixed LAT-cycle read pipeline, garbage on rdata when idle
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pa [LAT];
  initial begin
    for (int i = 0; i < LAT; i++) pa[i] = '0;
    forever begin
      @(posedge clk); #1;
      mem_rvld  = pv[LAT-1];
      mem_rdata = pv[LAT-1] ? mem_word(pa[LAT-1]) : 16'($urandom);
      for (int i = LAT-1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = mem_en && !mem_wr;
      pa[0] = mem_addr;
    end
  end

  // reference model: one transaction at a time, tracked as cycles-into-transaction
  bit          m_busy = 0, m_fin = 0, m_write = 0, m_own_d = 0, m_rr_d = 1, tie_d;
  int          m_t = 0, m_recv = 0;
  logic [15:0] m_addr = '0, m_wdata = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_fin = 0; m_t = 0; m_recv = 0; m_rr_d = 1;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (i_req || d_req) begin
`ifdef MEM_ARB_RR_EN
          tie_d = m_rr_d;
`else
          tie_d = 1;
`endif
          m_own_d = d_req && (!i_req || tie_d);
          m_rr_d  = !m_own_d;
          m_addr  = m_own_d ? d_addr : i_addr;
          m_wdata = d_wdata;
          m_write = m_own_d && d_wr;
          m_busy = 1; m_fin = 0; m_t = 0; m_recv = 0;
        end
      end else if (m_fin) begin
        m_busy = 0;
      end else if (m_write) begin
        m_fin = 1;
      end else begin
        if (mem_rvld) m_recv++;
        m_t++;
        if (m_recv == BURST) m_fin = 1;
      end
    end
  end

  // event logs used by the directed checks
  logic [15:0]   iss_a_q[$], iss_d_q[$], vld_v_q[$];
  bit            iss_w_q[$], vld_o_q[$], done_o_q[$];
  int            iss_c_q[$], vld_c_q[$], done_c_q[$];
  logic [IW-1:0] vld_i_q[$];

  logic        e_fill, e_wrc, e_en, e_vld;
  logic [15:0] e_addr;

  always @(negedge clk) begin
    e_fill = m_busy && !m_fin && !m_write;
    e_wrc  = m_busy && !m_fin && m_write;
    e_en   = (e_fill && m_t < BURST) || e_wrc;
    e_vld  = e_fill && mem_rvld;
    e_addr = m_write ? m_addr : ((m_addr & ~16'(2*BURST-1)) + 16'(2*m_t));
    chk("i_gnt",  i_gnt,  m_busy && !m_own_d);
    chk("d_gnt",  d_gnt,  m_busy && m_own_d);
    chk("i_vld",  i_vld,  e_vld && !m_own_d);
    chk("d_vld",  d_vld,  e_vld && m_own_d);
    chk("i_done", i_done, m_busy && m_fin && !m_own_d);
    chk("d_done", d_done, m_busy && m_fin && m_own_d);
    chk("mem_en", mem_en, e_en);
    chk("mem_wr", mem_wr, e_wrc);
    if (rst || e_en)  chk("mem_addr",  mem_addr,  rst ? 16'h0 : e_addr);
    if (rst || e_wrc) chk("mem_wdata", mem_wdata, rst ? 16'h0 : m_wdata);
    if (rst || e_vld) begin
      chk("fill_data", fill_data, rst ? 16'h0 : mem_rdata);
      chk("fill_idx",  fill_idx,  rst ? 0 : m_recv);
    end
    if (mem_rvld) n_rvld++;
    if (mem_en) begin
      iss_a_q.push_back(mem_addr); iss_w_q.push_back(mem_wr);
      iss_d_q.push_back(mem_wdata); iss_c_q.push_back(cyc);
    end
    if (i_vld || d_vld) begin
      vld_i_q.push_back(fill_idx); vld_v_q.push_back(fill_data);
      vld_o_q.push_back(d_vld); vld_c_q.push_back(cyc);
    end
    if (i_done || d_done) begin
      done_o_q.push_back(d_done); done_c_q.push_back(cyc);
    end
  end

  task automatic start_txn(input bit is_d, input bit wr, input logic [15:0] a, input logic [15:0] wd);
    int k = 0;
    @(posedge clk); #2;
    if (is_d) begin d_req = 1; d_wr = wr; d_addr = a; d_wdata = wd; end
    else begin i_req = 1; i_addr = a; end
    do begin @(negedge clk); k++; end while (!(is_d ? d_gnt : i_gnt) && k < 50);
    chk("grant_seen", is_d ? d_gnt : i_gnt, 1);
    @(posedge clk); #2;
    i_req = 0; d_req = 0; d_wr = 0;
  endtask

  task automatic wait_dones(input int target);
    int k = 0;
    while (done_o_q.size() < target && k < 300) begin @(posedge clk); k++; end
    chk("done_timeout", done_o_q.size() >= target, 1);
  endtask

  task automatic check_fill(input string nm, input int bi, input int bv, input int bd,
                            input logic [15:0] line, input bit own_d);
    chk({nm, "_issue_n"}, iss_a_q.size() - bi, BURST);
    chk({nm, "_vld_n"},   vld_i_q.size() - bv, BURST);
    for (int j = 0; j < BURST; j++) begin
      chk({nm, "_addr"},  iss_a_q[bi+j], line + 16'(2*j));
      chk({nm, "_rd"},    iss_w_q[bi+j], 0);
      chk({nm, "_idx"},   vld_i_q[bv+j], j);
      chk({nm, "_data"},  vld_v_q[bv+j], mem_word(line + 16'(2*j)));
      chk({nm, "_owner"}, vld_o_q[bv+j], own_d);
    end
    chk({nm, "_issue_consec"}, iss_c_q[bi+BURST-1] - iss_c_q[bi], BURST-1);
    chk({nm, "_latency"}, vld_c_q[bv] - iss_c_q[bi], LAT);
    chk({nm, "_done_owner"}, done_o_q[bd], own_d);
    chk({nm, "_done_time"}, done_c_q[bd] - vld_c_q[bv+BURST-1], 1);
  endtask

  task automatic pulse_rst;
    @(posedge clk); #2; rst = 1;
    @(posedge clk); #2; rst = 0;
  endtask

  int bi, bv, bd, r0, v0, d0;
  logic [2:0] exp_pat;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt",  {i_gnt, d_gnt}, 0);
    chk("reset_mem",  {mem_en, mem_wr}, 0);
    chk("reset_addr", mem_addr, 0);
    #1; rst = 0;

    // line fill from 0x0046 -> line 0x0040
    bi = iss_a_q.size(); bv = vld_i_q.size(); bd = done_o_q.size();
    start_txn(0, 0, 16'h0046, 16'h0);
    wait_dones(bd + 1);
    check_fill("ifill", bi, bv, bd, 16'h0040, 0);

    // single-word data write
    bi = iss_a_q.size(); bv = vld_i_q.size(); bd = done_o_q.size();
    start_txn(1, 1, 16'h1234, 16'hBEEF);
    wait_dones(bd + 1);
    chk("wr_issue_n", iss_a_q.size() - bi, 1);
    chk("wr_is_wr",   iss_w_q[bi], 1);
    chk("wr_addr",    iss_a_q[bi], 16'h1234);
    chk("wr_data",    iss_d_q[bi], 16'hBEEF);
    chk("wr_no_vld",  vld_i_q.size() - bv, 0);
    chk("wr_done_d",  done_o_q[bd], 1);
    chk("wr_done_t",  done_c_q[bd] - iss_c_q[bi], 1);

    // top-of-memory line must not wrap to 0x0000
    bi = iss_a_q.size(); bv = vld_i_q.size(); bd = done_o_q.size();
    start_txn(1, 0, 16'hFFFA, 16'h0);
    wait_dones(bd + 1);
    check_fill("dtop", bi, bv, bd, 16'hFFF0, 1);

    // requester drops right after the first fill cycle
    bi = iss_a_q.size(); bv = vld_i_q.size(); bd = done_o_q.size();
    start_txn(0, 0, 16'h0100, 16'h0);
    wait_dones(bd + 1);
    check_fill("drop", bi, bv, bd, 16'h0100, 0);

    // reset after the third return of a fill
    bv = vld_i_q.size(); d0 = done_o_q.size();
    @(posedge clk); #2; i_req = 1; i_addr = 16'h0200;
    begin
      int k = 0;
      while (vld_i_q.size() < bv + 3 && k < 50) begin @(posedge clk); k++; end
    end
    chk("rst_third_ret", vld_i_q.size() - bv, 3);
    #3; rst = 1; i_req = 0;
    #1;
    chk("rst_async_gnt",  {i_gnt, d_gnt}, 0);
    chk("rst_async_mem",  {mem_en, mem_wr, mem_addr}, 0);
    chk("rst_async_vld",  {i_vld, d_vld, i_done, d_done}, 0);
    chk("rst_async_fill", {fill_data, 13'(fill_idx)}, 0);
    r0 = n_rvld; v0 = vld_i_q.size();
    @(posedge clk); #3; rst = 0;
    repeat (10) @(posedge clk);
    chk("rst_stale_rvld", n_rvld - r0, 5);
    chk("rst_stale_vld",  vld_i_q.size() - v0, 0);
    chk("rst_no_done",    done_o_q.size() - d0, 0);
    bi = iss_a_q.size(); bv = vld_i_q.size(); bd = done_o_q.size();
    start_txn(0, 0, 16'h0300, 16'h0);
    wait_dones(bd + 1);
    check_fill("post_rst", bi, bv, bd, 16'h0300, 0);

    // simultaneous requests held for three grants
    pulse_rst();
    bd = done_o_q.size();
    @(posedge clk); #2;
    i_req = 1; i_addr = 16'h0400; d_req = 1; d_wr = 1; d_addr = 16'h2000; d_wdata = 16'h1111;
    begin
      int k = 0;
      while (done_o_q.size() < bd + 3 && k < 200) begin @(posedge clk); k++; end
    end
    #2; i_req = 0; d_req = 0; d_wr = 0;
`ifdef MEM_ARB_RR_EN
    exp_pat = 3'b101;
`else
    exp_pat = 3'b111;
`endif
    for (int j = 0; j < 3; j++) chk("tie_owner", done_o_q[bd+j], exp_pat[2-j]);
    repeat (30) @(posedge clk);

    // randomized traffic with occasional mid-flight resets
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk); #2;
      i_req   = ($urandom_range(0, 3) == 0);
      d_req   = ($urandom_range(0, 3) == 0);
      d_wr    = $urandom_range(0, 1);
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      rst     = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk); #2;
    i_req = 0; d_req = 0; rst = 0;
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
